// File: rtl/kxk_window_buffer_if.sv
// Pixel-stream in / KxK window out bundle for kxk_window_buffer.
// The master drives pixels; the slave (the buffer) returns windows and frame markers.
interface kxk_window_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int K          = 3
);
    logic                         valid_in;
    logic [DATA_WIDTH-1:0]        data;
    logic [K*K*DATA_WIDTH-1:0]    window;
    logic                         valid_out;
    logic                         frame_done;

    modport master (
        output valid_in,
        output data,
        input  window,
        input  valid_out,
        input  frame_done
    );

    modport slave (
        input  valid_in,
        input  data,
        output window,
        output valid_out,
        output frame_done
    );
endinterface

// File: rtl/kxk_window_buffer.sv
// Sliding KxK window over a raster pixel stream with stride, built from K-1
// column-indexed line delays plus a K-1 deep shift tap per window row.
module kxk_window_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH_IMG  = 28,
    parameter int HEIGHT_IMG = 28,
    parameter int K          = 3,
    parameter int STRIDE     = 1
) (
    input  logic               clk,
    input  logic               reset,
    kxk_window_buffer_if.slave bus
);
    localparam int CWC = $clog2(WIDTH_IMG);
    localparam int RWC = $clog2(HEIGHT_IMG);
    localparam int PW  = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int WW  = K * K * DATA_WIDTH;

    // Phase of the next position relative to the first legal one; positions
    // before the first legal one sit at phase 0 so counting starts there.
    function automatic logic [PW-1:0] phase_next(input int pos_next, input logic [PW-1:0] ph);
        if (pos_next <= K - 1 || ph == PW'(STRIDE - 1)) return '0;
        return ph + PW'(1);
    endfunction

    logic [CWC-1:0]        col_p0;
    logic [RWC-1:0]        row_p0;
    logic [PW-1:0]         col_ph_p0;
    logic [PW-1:0]         row_ph_p0;
    logic                  accept_p0;
    logic                  col_last_p0;
    logic                  row_last_p0;
    logic                  legal_p0;

    logic [DATA_WIDTH-1:0] line_mem [K-1][WIDTH_IMG];
    logic [DATA_WIDTH-1:0] tap_p0   [K][K-1];
    logic [DATA_WIDTH-1:0] col_px   [K];
    logic [WW-1:0]         win_next;

    logic [WW-1:0]         window_p1;
    logic                  vld_p1;
    logic                  done_p1;

    // p0: pixel accept, position tracking and window assembly
    always_comb begin
        accept_p0   = bus.valid_in && !reset;
        col_last_p0 = (col_p0 == CWC'(WIDTH_IMG - 1));
        row_last_p0 = (row_p0 == RWC'(HEIGHT_IMG - 1));
        legal_p0    = (col_p0 >= CWC'(K - 1)) && (row_p0 >= RWC'(K - 1)) &&
                      (col_ph_p0 == '0) && (row_ph_p0 == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_p0    <= '0;
            row_p0    <= '0;
            col_ph_p0 <= '0;
            row_ph_p0 <= '0;
        end else if (bus.valid_in) begin
            if (col_last_p0) begin
                col_p0    <= '0;
                col_ph_p0 <= '0;
                if (row_last_p0) begin
                    row_p0    <= '0;
                    row_ph_p0 <= '0;
                end else begin
                    row_p0    <= row_p0 + RWC'(1);
                    row_ph_p0 <= phase_next(int'(row_p0) + 1, row_ph_p0);
                end
            end else begin
                col_p0    <= col_p0 + CWC'(1);
                col_ph_p0 <= phase_next(int'(col_p0) + 1, col_ph_p0);
            end
        end
    end

    // Line j at index col holds the pixel j+1 rows above the current one.
    always_comb begin
        col_px[0] = bus.data;
        for (int j = 0; j < K - 1; j++) begin
            col_px[j+1] = line_mem[j][col_p0];
        end
    end

    always_ff @(posedge clk) begin
        if (accept_p0) begin
            line_mem[0][col_p0] <= bus.data;
            for (int j = 1; j < K - 1; j++) begin
                line_mem[j][col_p0] <= line_mem[j-1][col_p0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept_p0) begin
            for (int r = 0; r < K; r++) begin
                tap_p0[r][0] <= col_px[r];
                for (int c = 1; c < K - 1; c++) begin
                    tap_p0[r][c] <= tap_p0[r][c-1];
                end
            end
        end
    end

    // Row r / column c back from the current pixel lands in slot (K-1-r)*K + (K-1-c).
    always_comb begin
        win_next = '0;
        for (int r = 0; r < K; r++) begin
            win_next[((K-1-r)*K + (K-1))*DATA_WIDTH +: DATA_WIDTH] = col_px[r];
            for (int c = 1; c < K; c++) begin
                win_next[((K-1-r)*K + (K-1-c))*DATA_WIDTH +: DATA_WIDTH] = tap_p0[r][c-1];
            end
        end
    end

    // p1: registered window and frame markers
    always_ff @(posedge clk) begin
        if (reset) begin
            window_p1 <= '0;
            vld_p1    <= 1'b0;
            done_p1   <= 1'b0;
        end else begin
            vld_p1  <= bus.valid_in && legal_p0;
            done_p1 <= bus.valid_in && col_last_p0 && row_last_p0;
            if (bus.valid_in && legal_p0) begin
                window_p1 <= win_next;
            end
        end
    end

    assign bus.window     = window_p1;
    assign bus.valid_out  = vld_p1;
    assign bus.frame_done = done_p1;

endmodule

// File: tb/tb_kxk_window_buffer.sv
// Directed bench for kxk_window_buffer: three configurations checked against
// hand-derived window contents, pulse counts and latencies.
module tb_kxk_window_buffer;
    typedef struct {
        logic [199:0] win;
        logic         fd;
        int           cyc;
    } ent_t;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   acc [64];
    ent_t qa[$], qb[$], qc[$];
    int   fd_a = 0, fd_b = 0, fd_c = 0;
    int   vio_a = 0;
    logic prev_vin_a = 1'b0;

    kxk_window_buffer_if #(.DATA_WIDTH(8), .K(3)) ifa();
    kxk_window_buffer_if #(.DATA_WIDTH(8), .K(3)) ifb();
    kxk_window_buffer_if #(.DATA_WIDTH(8), .K(5)) ifc();

    kxk_window_buffer #(.DATA_WIDTH(8), .WIDTH_IMG(4), .HEIGHT_IMG(4), .K(3), .STRIDE(1))
        dut_a (.clk(clk), .reset(rst_a), .bus(ifa));
    kxk_window_buffer #(.DATA_WIDTH(8), .WIDTH_IMG(6), .HEIGHT_IMG(6), .K(3), .STRIDE(2))
        dut_b (.clk(clk), .reset(rst_b), .bus(ifb));
    kxk_window_buffer #(.DATA_WIDTH(8), .WIDTH_IMG(5), .HEIGHT_IMG(5), .K(5), .STRIDE(1))
        dut_c (.clk(clk), .reset(rst_c), .bus(ifc));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ent_t e;
        if (ifa.valid_out) begin
            e.win = 200'(ifa.window); e.fd = ifa.frame_done; e.cyc = cyc;
            qa.push_back(e);
        end
        if (ifa.frame_done) fd_a++;
        if (ifa.valid_out && !prev_vin_a) vio_a++;
        prev_vin_a = ifa.valid_in;
    end

    always @(negedge clk) begin
        ent_t e;
        if (ifb.valid_out) begin
            e.win = 200'(ifb.window); e.fd = ifb.frame_done; e.cyc = cyc;
            qb.push_back(e);
        end
        if (ifb.frame_done) fd_b++;
    end

    always @(negedge clk) begin
        ent_t e;
        if (ifc.valid_out) begin
            e.win = 200'(ifc.window); e.fd = ifc.frame_done; e.cyc = cyc;
            qc.push_back(e);
        end
        if (ifc.frame_done) fd_c++;
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int slot(input logic [199:0] w, input int i);
        return int'(w[i*8 +: 8]);
    endfunction

    // 3x3 window whose bottom-right is frame pixel p of a W-wide image.
    task automatic check_win3(input string tag, input logic [199:0] w,
                              input int base, input int p, input int W);
        for (int i = 0; i < 9; i++) begin
            check_eq($sformatf("%s_s%0d", tag, i), slot(w, i),
                     base + p - (2 - i / 3) * W - (2 - i % 3));
        end
    endtask

    task automatic drive(input int which, input logic vi, input int d);
        @(posedge clk);
        #1;
        case (which)
            0:       begin ifa.valid_in = vi; ifa.data = 8'(d); end
            1:       begin ifb.valid_in = vi; ifb.data = 8'(d); end
            default: begin ifc.valid_in = vi; ifc.data = 8'(d); end
        endcase
    endtask

    task automatic stream(input int which, input int base, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) drive(which, 1'b0, 0);
            drive(which, 1'b1, base + i);
            acc[i] = cyc + 1;
        end
    endtask

    task automatic idle(input int which, input int n);
        repeat (n) drive(which, 1'b0, 0);
    endtask

    task automatic check_frame_a(input string tag, input int base);
        int bp [4] = '{10, 11, 14, 15};
        check_eq({tag, "_count"}, qa.size(), 4);
        if (qa.size() >= 4) begin
            for (int k = 0; k < 4; k++) check_win3($sformatf("%s_w%0d", tag, k), qa[k].win, base, bp[k], 4);
            check_eq({tag, "_fd_first"}, qa[0].fd, 0);
            check_eq({tag, "_fd_last"}, qa[3].fd, 1);
        end
    endtask

    initial begin
        ifa.valid_in = 0; ifa.data = 0;
        ifb.valid_in = 0; ifb.data = 0;
        ifc.valid_in = 0; ifc.data = 0;
        rst_a = 1; rst_b = 1; rst_c = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_vout_a", ifa.valid_out, 0);
        check_eq("rst_fd_a", ifa.frame_done, 0);
        check_eq("rst_win_a", |ifa.window, 0);
        check_eq("rst_win_c", |ifc.window, 0);
        @(posedge clk);
        #1;
        rst_a = 0; rst_b = 0; rst_c = 0;

        // 4x4, K=3, S=1 basic frame
        qa.delete(); fd_a = 0;
        stream(0, 0, 16, 1'b0);
        idle(0, 4);
        check_frame_a("basic", 0);
        if (qa.size() >= 1) check_eq("basic_lat", qa[0].cyc, acc[10]);
        if (qa.size() >= 4) check_eq("basic_lat_last", qa[3].cyc, acc[15]);
        check_eq("basic_fd_count", fd_a, 1);
        check_eq("basic_hold_s8", slot(200'(ifa.window), 8), 15);
        check_eq("basic_hold_s0", slot(200'(ifa.window), 0), 5);

        // same frame with random input gaps
        qa.delete(); fd_a = 0;
        stream(0, 0, 16, 1'b1);
        idle(0, 4);
        check_frame_a("gaps", 0);
        check_eq("gaps_fd_count", fd_a, 1);
        check_eq("gaps_no_vout_after_idle", vio_a, 0);

        // two frames back to back
        qa.delete(); fd_a = 0;
        stream(0, 0, 16, 1'b0);
        stream(0, 100, 16, 1'b0);
        idle(0, 4);
        check_eq("b2b_count", qa.size(), 8);
        if (qa.size() >= 8) begin
            check_win3("b2b_f1w0", qa[0].win, 0, 10, 4);
            check_win3("b2b_f1w3", qa[3].win, 0, 15, 4);
            check_win3("b2b_f2w0", qa[4].win, 100, 10, 4);
            check_win3("b2b_f2w1", qa[5].win, 100, 11, 4);
            check_win3("b2b_f2w3", qa[7].win, 100, 15, 4);
        end
        check_eq("b2b_fd_count", fd_a, 2);

        // mid-frame reset after pixel 9, pixel in the reset cycle dropped
        qa.delete(); fd_a = 0;
        stream(0, 0, 10, 1'b0);
        @(posedge clk);
        #1;
        rst_a = 1; ifa.valid_in = 1; ifa.data = 8'd77;
        @(posedge clk);
        #1;
        rst_a = 0; ifa.valid_in = 0;
        @(negedge clk);
        check_eq("mrst_vout", ifa.valid_out, 0);
        check_eq("mrst_fd", ifa.frame_done, 0);
        check_eq("mrst_win", |ifa.window, 0);
        stream(0, 0, 16, 1'b0);
        idle(0, 4);
        check_frame_a("mrst", 0);
        if (qa.size() >= 1) check_eq("mrst_lat", qa[0].cyc, acc[10]);
        check_eq("mrst_fd_count", fd_a, 1);
        check_eq("mrst_no_vout_after_idle", vio_a, 0);

        // 6x6, K=3, S=2
        qb.delete(); fd_b = 0;
        stream(1, 0, 36, 1'b0);
        idle(1, 4);
        check_eq("s2_count", qb.size(), 4);
        if (qb.size() >= 4) begin
            check_eq("s2_br0", slot(qb[0].win, 8), 14);
            check_eq("s2_br1", slot(qb[1].win, 8), 16);
            check_eq("s2_br2", slot(qb[2].win, 8), 26);
            check_eq("s2_br3", slot(qb[3].win, 8), 28);
            check_win3("s2_w0", qb[0].win, 0, 14, 6);
            check_win3("s2_w3", qb[3].win, 0, 28, 6);
            check_eq("s2_lat", qb[1].cyc, acc[16]);
        end
        check_eq("s2_fd_count", fd_b, 1);

        // 5x5, K=5: one full-image window
        qc.delete(); fd_c = 0;
        stream(2, 0, 25, 1'b0);
        idle(2, 4);
        check_eq("k5_count", qc.size(), 1);
        if (qc.size() >= 1) begin
            for (int i = 0; i < 25; i++) check_eq($sformatf("k5_s%0d", i), slot(qc[0].win, i), i);
            check_eq("k5_lat", qc[0].cyc, acc[24]);
            check_eq("k5_fd", qc[0].fd, 1);
        end
        check_eq("k5_fd_count", fd_c, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
